// File: rtl/dijkstra_path_reader.sv
// -----------------------------------------------------------------------------
// dijkstra_path_reader
//
// Purpose:
//    Reads back the prev[] table that DijkstraTop leaves in BlockRam after a
//    solve. Starting at the destination it follows prev[] links towards the
//    source over the shared memory bus and streams the path one node at a time
//    through a valid/ready handshake. It is a read-only initiator on the bus.
//    It drives the bus only while busy and otherwise releases it to 'z.
//
// Optional feature (macro PATH_REVERSE_EN):
//    When defined, visited nodes are pushed into a MAX_NODES-deep LIFO during
//    the walk. Nothing is streamed while walking. The LIFO is then drained
//    source-first, with path_last on the destination. If the walk fails, the
//    stream stays empty and done and error rise together. This adds the DRAIN
//    state. When undefined, nodes stream destination-first and there is no
//    LIFO storage.
//
// Ports:
//    clock, reset          system clock; synchronous active-high reset
//    start                 one-cycle walk request, sampled only while idle
//    source                node that terminates the walk
//    destination           node the walk starts from
//    number_of_nodes       N of the solved graph
//    base_address          graph base; prev[] starts at base + N*N words
//    mem_read_enable       read strobe ('z when not busy)
//    mem_addr              read address ('z when not busy)
//    mem_read_ready        read data valid from BlockRam
//    mem_read_data         read data; low INDEX_WIDTH bits hold prev[node]
//    path_node             current path element
//    path_valid            path_node is valid
//    path_ready            downstream accepts when valid and ready
//    path_last             marks the final element of the stream
//    busy                  walk in progress
//    done                  one-cycle completion pulse
//    error                 sticky until next start: unreachable, cycle or bad index
// -----------------------------------------------------------------------------

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 32
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 32
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 16
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 8
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE '1
`endif

module dijkstra_path_reader #(
   parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
   parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
   parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [INDEX_WIDTH-1:0] source,
   input  logic [INDEX_WIDTH-1:0] destination,
   input  logic [INDEX_WIDTH-1:0] number_of_nodes,
   input  logic [MADDR_WIDTH-1:0] base_address,
   output logic                   mem_read_enable,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   input  logic                   mem_read_ready,
   input  logic [MDATA_WIDTH-1:0] mem_read_data,
   output logic [INDEX_WIDTH-1:0] path_node,
   output logic                   path_valid,
   input  logic                   path_ready,
   output logic                   path_last,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam logic [MADDR_WIDTH-1:0] STRIDE  = MADDR_WIDTH'(MADDR_WIDTH / 8);
   localparam logic [INDEX_WIDTH-1:0] NO_PREV = `NO_PREVIOUS_NODE;
   localparam logic [INDEX_WIDTH:0]   MAX_N   = (INDEX_WIDTH + 1)'(MAX_NODES);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      EMIT,
      DRAIN,
      FINISH
   } state_t;

   state_t state, state_n;

   logic [INDEX_WIDTH-1:0] node_r;
   logic [INDEX_WIDTH-1:0] src_r;
   logic [INDEX_WIDTH-1:0] n_r;
   logic [MADDR_WIDTH-1:0] base_r;
   logic [INDEX_WIDTH-1:0] prev_r;
   logic [INDEX_WIDTH:0]   steps_r;
   logic                   error_r;

   logic                   rd_en;
   logic [MADDR_WIDTH-1:0] addr_c;
   logic                   bad_start;
   logic                   at_source;
   logic                   prev_bad;
   logic                   guard_hit;
   logic                   elem_last;
   logic                   elem_error;
   logic                   emit_accept;
   logic                   unused_data;

   // Only the low INDEX_WIDTH bits of a memory word carry the prev[] entry.
   assign unused_data = ^mem_read_data;

   // A request is rejected up front when either endpoint lies outside the graph
   // or the graph is larger than the walk bound / LIFO can cover.
   assign bad_start = (destination >= number_of_nodes) ||
                      (source >= number_of_nodes) ||
                      ({1'b0, number_of_nodes} > MAX_N);

   // Termination conditions for the element currently held in EMIT. A prev
   // entry outside the graph, including the no-previous marker, means the
   // destination is unreachable. Reaching N elements without hitting the
   // source means prev[] contains a cycle.
   assign at_source  = (node_r == src_r);
   assign prev_bad   = (prev_r == NO_PREV) || (prev_r >= n_r);
   assign guard_hit  = (steps_r == {1'b0, n_r});
   assign elem_last  = at_source || prev_bad || guard_hit;
   assign elem_error = !at_source && (prev_bad || guard_hit);

`ifdef PATH_REVERSE_EN
   // Walk elements go straight into the LIFO, so no downstream handshake is needed.
   assign emit_accept = 1'b1;
`else
   assign emit_accept = path_ready;
`endif

   // prev[node] lives at word N*N + node past the graph base.
   assign addr_c = base_r + ((MADDR_WIDTH'(n_r) * MADDR_WIDTH'(n_r)) + MADDR_WIDTH'(node_r)) * STRIDE;

   // The bus is shared with DijkstraTop, so it is driven only while this block is busy.
   assign mem_read_enable = busy ? rd_en  : 1'bz;
   assign mem_addr        = busy ? addr_c : {MADDR_WIDTH{1'bz}};
   assign error           = error_r;

`ifdef PATH_REVERSE_EN
   localparam int SPW = $clog2(MAX_NODES + 1);

   logic [INDEX_WIDTH-1:0] lifo [MAX_NODES];
   logic [SPW-1:0]         sp;
   logic [SPW-1:0]         top;

   assign top = sp - 1'b1;

   // Stack pointer: emptied on every idle cycle, grows while walking and
   // shrinks as drained elements are accepted downstream.
   always_ff @(posedge clock) begin
      if (reset) begin
         sp <= '0;
      end else if (state == IDLE) begin
         sp <= '0;
      end else if (state == EMIT && !elem_error) begin
         sp <= sp + 1'b1;
      end else if (state == DRAIN && path_ready) begin
         sp <= sp - 1'b1;
      end
   end

   // LIFO storage needs no reset; sp tracks which entries are meaningful.
   always_ff @(posedge clock) begin
      if (state == EMIT && !elem_error) begin
         lifo[sp] <= node_r;
      end
   end
`endif

   // Next-state and output decode. Every output defaults to its idle value first.
   always_comb begin
      state_n    = state;
      rd_en      = 1'b0;
      path_valid = 1'b0;
      path_last  = 1'b0;
      path_node  = '0;
      done       = 1'b0;
      busy       = (state != IDLE) && (state != FINISH);
      case (state)
         IDLE: begin
            if (start) begin
               if (bad_start) begin
                  state_n = FINISH;
               end else if (destination == source) begin
                  state_n = EMIT;
               end else begin
                  state_n = REQ;
               end
            end
         end
         REQ: begin
            rd_en   = 1'b1;
            state_n = WAIT;
         end
         WAIT: begin
            rd_en = 1'b1;
            if (mem_read_ready) begin
               state_n = EMIT;
            end
         end
         EMIT: begin
`ifdef PATH_REVERSE_EN
            if (elem_error) begin
               state_n = FINISH;
            end else if (at_source) begin
               state_n = DRAIN;
            end else begin
               state_n = REQ;
            end
`else
            path_valid = 1'b1;
            path_node  = node_r;
            path_last  = elem_last;
            if (path_ready) begin
               state_n = elem_last ? FINISH : REQ;
            end
`endif
         end
         DRAIN: begin
`ifdef PATH_REVERSE_EN
            path_valid = 1'b1;
            path_node  = lifo[top];
            path_last  = (sp == SPW'(1));
            if (path_ready && sp == SPW'(1)) begin
               state_n = FINISH;
            end
`else
            state_n = IDLE;
`endif
         end
         FINISH: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State register and walk bookkeeping. The request is latched in IDLE.
   // The error flag stays set until the next accepted start.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         node_r  <= '0;
         src_r   <= '0;
         n_r     <= '0;
         base_r  <= '0;
         prev_r  <= '0;
         steps_r <= '0;
         error_r <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (start) begin
                  node_r  <= destination;
                  src_r   <= source;
                  n_r     <= number_of_nodes;
                  base_r  <= base_address;
                  steps_r <= (INDEX_WIDTH + 1)'(1);
                  error_r <= bad_start;
               end
            end
            WAIT: begin
               if (mem_read_ready) begin
                  prev_r <= mem_read_data[INDEX_WIDTH-1:0];
               end
            end
            EMIT: begin
               if (emit_accept) begin
                  if (elem_error) begin
                     error_r <= 1'b1;
                  end else if (!elem_last) begin
                     node_r  <= prev_r;
                     steps_r <= steps_r + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
